aes_round_sequencer: RTL and testbench

Sequences one shared single-round AES datapath through the 11 AddRoundKey steps of AES-128 encryption for each 128-bit block. It takes the 1408-bit round-key schedule from KeyExpansion and selects the 128-bit round key for each step. It drives the datapath control strobes (load, round enable, first/last flags) and applies valid/ready handshakes on input and output. It sits between the USB-side block buffer and the round datapath.

---
 rtl/aes_pkg.sv | 10 +
 rtl/aes_round_sequencer_if.sv | 26 ++
 rtl/aes_rk_mux.sv | 18 +
 rtl/aes_round_sequencer.sv | 95 +++++++++
 tb/tb_aes_round_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, round count and types for the AES round sequencer slice
// Provides: AES_KEY_W, AES_BLK_W, AES_NR, AES_SCHED_W, aes_seq_state_t, rk_idx_t
package aes_pkg;
   localparam int AES_KEY_W   = 128;
   localparam int AES_BLK_W   = 128;
   localparam int AES_NR      = 10;
   localparam int AES_SCHED_W = 1408;
   typedef enum logic [1:0] {IDLE, INIT, ROUND, HOLD} aes_seq_state_t;
   typedef logic [3:0] rk_idx_t;
endpackage

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: key schedule, block handshakes and datapath strobes
// master: sequencer side (drives in_ready, out_valid, round_key, rk_sel, strobes, busy)
// slave:  buffer/datapath side (drives sched, sched_valid, in_valid, out_ready)
interface aes_round_sequencer_if;
   import aes_pkg::*;
   logic [0:AES_SCHED_W-1] sched;
   logic                   sched_valid;
   logic                   in_valid;
   logic                   in_ready;
   logic                   out_valid;
   logic                   out_ready;
   logic [0:AES_KEY_W-1]   round_key;
   rk_idx_t                rk_sel;
   logic                   state_load;
   logic                   rnd_en;
   logic                   rnd_last;
   logic                   busy;
   modport master (
      input  sched, sched_valid, in_valid, out_ready,
      output in_ready, out_valid, round_key, rk_sel, state_load, rnd_en, rnd_last, busy
   );
   modport slave (
      output sched, sched_valid, in_valid, out_ready,
      input  in_ready, out_valid, round_key, rk_sel, state_load, rnd_en, rnd_last, busy
   );
endinterface

// File: rtl/aes_rk_mux.sv
// aes_rk_mux: combinational selection of one 128-bit round key from the schedule
// sched: NR+1 keys, key k at sched[k*128 +: 128]; sel: key index; key: selected key
module aes_rk_mux
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic [0:AES_SCHED_W-1] sched,
   input  rk_idx_t                sel,
   output logic [0:AES_KEY_W-1]   key
);
   // Compare-and-select keeps every slice constant, so no index can run off the schedule.
   always_comb begin
      key = '0;
      for (int i = 0; i <= NR; i++)
         if (sel == rk_idx_t'(i)) key = sched[i*AES_KEY_W +: AES_KEY_W];
   end
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: steps a shared AES round datapath through the NR+1 AddRoundKey steps
// clk, rst: clock and synchronous active-high reset
// bus: schedule + valid, in/out handshakes, round_key/rk_sel, state_load/rnd_en/rnd_last, busy
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter int NR      = AES_NR,
   parameter int RND_LAT = 1
) (
   input logic                   clk,
   input logic                   rst,
   aes_round_sequencer_if.master bus
);
   localparam logic [1:0] LAT_MAX = 2'(RND_LAT - 1);
   localparam rk_idx_t    RK_MAX  = rk_idx_t'(NR);
   aes_seq_state_t state;
   rk_idx_t        rk_sel;
   logic [1:0]     lat_cnt;
   logic           ld_q, rn_q, in_ready_q, out_valid_q, rnd_last_q, busy_q;
   logic           lat_done;
   assign lat_done = lat_cnt == LAT_MAX;
   aes_rk_mux #(.NR(NR)) u_rk_mux (.sched(bus.sched), .sel(rk_sel), .key(bus.round_key));
   assign bus.rk_sel    = rk_sel;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.rnd_last  = rnd_last_q;
   assign bus.busy      = busy_q;
   // A pending strobe stays armed while the schedule is invalid and fires on the resume cycle.
   assign bus.state_load = ld_q & bus.sched_valid;
   assign bus.rnd_en     = rn_q & bus.sched_valid;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rk_sel      <= '0;
         lat_cnt     <= '0;
         ld_q        <= 1'b0;
         rn_q        <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         rnd_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  state      <= INIT;
                  rk_sel     <= '0;
                  lat_cnt    <= '0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
                  ld_q       <= 1'b1;
               end else in_ready_q <= bus.sched_valid;
            end
            INIT: begin
               if (bus.sched_valid) begin
                  ld_q <= 1'b0;
                  if (lat_done) begin
                     state      <= ROUND;
                     rk_sel     <= rk_idx_t'(1);
                     lat_cnt    <= '0;
                     rn_q       <= 1'b1;
                     rnd_last_q <= RK_MAX == rk_idx_t'(1);
                  end else lat_cnt <= lat_cnt + 2'd1;
               end
            end
            ROUND: begin
               if (bus.sched_valid) begin
                  rn_q <= 1'b0;
                  if (lat_done && rk_sel == RK_MAX) begin
                     state       <= HOLD;
                     lat_cnt     <= '0;
                     rnd_last_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else if (lat_done) begin
                     rk_sel     <= rk_idx_t'(rk_sel + 1'b1);
                     lat_cnt    <= '0;
                     rn_q       <= 1'b1;
                     rnd_last_q <= rk_idx_t'(rk_sel + 1'b1) == RK_MAX;
                  end else lat_cnt <= lat_cnt + 2'd1;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  rk_sel      <= '0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= bus.sched_valid;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed checks of sequencing, stalls, backpressure and ciphertext
module tb_aes_round_sequencer;
   logic         clk, rst;
   logic [127:0] blk, st;
   logic [7:0]   sbox [256];
   logic [0:1407] sched;
   int           tests, fails, n;

   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] P3  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] C3  = 128'hf5d3d58503b9699de785895a96fdbaaf;

   aes_round_sequencer_if i1();
   aes_round_sequencer_if i2();
   aes_round_sequencer #(.RND_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
   aes_round_sequencer #(.RND_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [127:0] rnd(input logic [127:0] s, input logic [127:0] k, input logic last);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [7:0]   x0, x1, x2, x3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
         o[127-32*c -: 32] = last ? {x0, x1, x2, x3} :
            {xt(x0)^xt(x1)^x1^x2^x3, x0^xt(x1)^xt(x2)^x2^x3,
             x0^x1^xt(x2)^xt(x3)^x3, xt(x0)^x0^x1^x2^xt(x3)};
      end
      return o ^ k;
   endfunction

   function automatic logic [0:1407] kexp(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [0:1407] s;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) s[32*i +: 32] = w[i];
      return s;
   endfunction

   // behavioural datapath state register driven by dut1 strobes
   always @(posedge clk)
      if (i1.state_load) st <= blk ^ i1.round_key;
      else if (i1.rnd_en) st <= rnd(st, i1.round_key, i1.rnd_last);

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, i1.in_ready, 0);
      chk({tag, "_out_valid"}, i1.out_valid, 0);
      chk({tag, "_state_load"}, i1.state_load, 0);
      chk({tag, "_rnd_en"}, i1.rnd_en, 0);
      chk({tag, "_rnd_last"}, i1.rnd_last, 0);
      chk({tag, "_busy"}, i1.busy, 0);
      chk({tag, "_rk_sel"}, i1.rk_sel, 0);
   endtask

   task automatic start(input logic [127:0] p);
      int k = 0;
      @(negedge clk);
      while (!i1.in_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("start_in_ready", i1.in_ready, 1);
      blk = p;
      i1.in_valid = 1'b1;
      @(negedge clk);
      i1.in_valid = 1'b0;
   endtask

   task automatic wait_ov(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!i1.out_valid && k < 60);
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; blk = '0;
      i1.in_valid = 1'b0; i1.out_ready = 1'b1; i1.sched_valid = 1'b0; i1.sched = '0;
      i2.in_valid = 1'b0; i2.out_ready = 1'b1; i2.sched_valid = 1'b0; i2.sched = '0;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = 8'h01;
         for (int j = 0; j < 254; j++) v = gm(v, 8'(i));
         sbox[i] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      end
      sched = kexp(KEY);
      i1.sched = sched; i1.sched_valid = 1'b1;
      i2.sched = sched; i2.sched_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      // single block, RND_LAT=1
      start(P1);
      for (int c = 1; c <= 13; c++) begin
         chk("t1_state_load", i1.state_load, c == 1);
         chk("t1_rnd_en", i1.rnd_en, c >= 2 && c <= 11);
         chk("t1_rnd_last", i1.rnd_last, c == 11);
         chk("t1_rk_sel", i1.rk_sel, (c >= 2 && c <= 12) ? (c > 11 ? 10 : c - 1) : 0);
         chk("t1_out_valid", i1.out_valid, c == 12);
         chk("t1_busy", i1.busy, c <= 12);
         if (c == 1) chk("t1_rk0", i1.round_key, KEY);
         if (c == 11) chk("t1_rk10", i1.round_key, K10);
         if (c == 12) chk("t1_cipher", st, C1);
         if (c == 13) chk("t1_in_ready_after", i1.in_ready, 1);
         @(negedge clk);
      end

      // backpressure: HOLD with out_ready low
      i1.out_ready = 1'b0;
      start(P2);
      repeat (11) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", i1.out_valid, 1);
         chk("bp_rnd_en", i1.rnd_en, 0);
         chk("bp_in_ready", i1.in_ready, 0);
         chk("bp_cipher", st, C2);
         @(negedge clk);
      end
      i1.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_exit_out_valid", i1.out_valid, 0);
      chk("bp_exit_busy", i1.busy, 0);
      chk("bp_exit_in_ready", i1.in_ready, 1);

      // schedule stall at rk_sel=4
      start(P1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      i1.sched_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_rk_sel", i1.rk_sel, 4);
         chk("stall_rnd_en", i1.rnd_en, 0);
         chk("stall_state_load", i1.state_load, 0);
      end
      @(posedge clk); #1;
      i1.sched_valid = 1'b1;
      @(negedge clk);
      chk("resume_rk_sel", i1.rk_sel, 4);
      chk("resume_rnd_en", i1.rnd_en, 1);
      wait_ov(n);
      chk("stall_latency", n, 7);
      chk("stall_cipher", st, C1);

      // reset mid-block at rk_sel=6
      start(P1);
      repeat (6) @(negedge clk);
      chk("pre_reset_rk_sel", i1.rk_sel, 6);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("midreset");
      rst = 1'b0;
      start(P3);
      wait_ov(n);
      chk("after_reset_latency", n, 11);
      chk("after_reset_cipher", st, C3);

      // back-to-back with in_valid held high
      blk = P1;
      i1.in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready1", i1.in_ready, 1);
      chk("b2b_out_valid_idle", i1.out_valid, 0);
      wait_ov(n);
      chk("b2b_latency1", n, 12);
      chk("b2b_cipher1", st, C1);
      blk = P2;
      @(negedge clk);
      chk("b2b_in_ready2", i1.in_ready, 1);
      wait_ov(n);
      chk("b2b_latency2", n, 12);
      chk("b2b_cipher2", st, C2);
      i1.in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_busy_end", i1.busy, 0);

      // RND_LAT=2 timing on dut2
      begin
         int k = 0, n_rnd = 0, n_ld = 0;
         while (!i2.in_ready && k < 40) begin
            @(negedge clk);
            k++;
         end
         chk("l2_in_ready", i2.in_ready, 1);
         i2.in_valid = 1'b1;
         for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1) i2.in_valid = 1'b0;
            n_rnd += int'(i2.rnd_en);
            n_ld += int'(i2.state_load);
            chk("l2_rnd_en", i2.rnd_en, c >= 3 && c <= 21 && c % 2 == 1);
            chk("l2_state_load", i2.state_load, c == 1);
            chk("l2_out_valid", i2.out_valid, c == 23);
         end
         chk("l2_rnd_count", n_rnd, 10);
         chk("l2_load_count", n_ld, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
